// File: rtl/wb_regfile.sv
// MEM/WB pipeline register plus 32-entry register file with WB bypass.
// Define WB_FWD_MEM_EN to add a MEM-stage read bypass ahead of the WB one.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic              mem_wr_en,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic              wb_wr_en,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_wdata <= '0;
      wb_waddr <= '0;
      wb_wr_en <= 1'b0;
    end else if (flush) begin
      wb_wdata <= '0;
      wb_waddr <= '0;
      wb_wr_en <= 1'b0;
    end else if (!stall) begin
      wb_wdata <= mem_wdata;
      wb_waddr <= mem_waddr;
      wb_wr_en <= mem_wr_en;
    end
  end

  // Commit ignores stall/flush: the held entry re-writes the same value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wb_wr_en && (wb_waddr != '0)) begin
      regs[wb_waddr] <= wb_wdata;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(
    input logic              en,
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] d;
    d = regs[a];
    if (!rst)
      d = '0;
    else if (!en)
      d = '0;
    else if (a == '0)
      d = '0;
`ifdef WB_FWD_MEM_EN
    else if (mem_wr_en && (a == mem_waddr))
      d = mem_wdata;
`endif
    else if (wb_wr_en && (a == wb_waddr))
      d = wb_wdata;
    return d;
  endfunction

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    rdata1 = rd_port(re1, raddr1);
    rdata2 = rd_port(re2, raddr2);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; expectations queued, then popped
// and compared against the DUT outputs.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_waddr;
  logic        mem_wr_en;
  logic [31:0] wb_wdata;
  logic [4:0]  wb_waddr;
  logic        wb_wr_en;
  logic        re1;
  logic        re2;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .mem_wdata (mem_wdata),
    .mem_waddr (mem_waddr),
    .mem_wr_en (mem_wr_en),
    .wb_wdata  (wb_wdata),
    .wb_waddr  (wb_waddr),
    .wb_wr_en  (wb_wr_en),
    .re1       (re1),
    .re2       (re2),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rdata1    (rdata1),
    .rdata2    (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty got %h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s got %h exp %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    mem_wr_en = 1'b1;
    mem_waddr = 5'd5;
    mem_wdata = 32'hDEADBEEF;
    re1 = 1'b1;
    re2 = 1'b0;
    raddr1 = 5'd5;
    raddr2 = 5'd0;

    push("rst_wb_en", 32'h0);
    push("rst_wb_addr", 32'h0);
    push("rst_wb_data", 32'h0);
    push("rst_rd1", 32'h0);
    push("rst_rd2", 32'h0);
    step();
    step();
    pop({31'b0, wb_wr_en});
    pop({27'b0, wb_waddr});
    pop(wb_wdata);
    pop(rdata1);
    pop(rdata2);

    rst = 1'b1;
    #1;
    push("pre_cap_r5", 32'h0);
    pop(rdata1);
    push("cap_r5_byp", 32'hDEADBEEF);
    step();
    pop(rdata1);

    mem_waddr = 5'd3;
    mem_wdata = 32'h12345678;
    push("r3_byp1", 32'h12345678);
    push("r3_byp2", 32'h12345678);
    push("r3_wbaddr", 32'd3);
    step();
    mem_wr_en = 1'b0;
    raddr1 = 5'd3;
    raddr2 = 5'd3;
    re2 = 1'b1;
    #1;
    pop(rdata1);
    pop(rdata2);
    pop({27'b0, wb_waddr});

    push("r3_arr1", 32'h12345678);
    push("r3_arr2", 32'h12345678);
    push("wb_en_off", 32'h0);
    step();
    pop(rdata1);
    pop(rdata2);
    pop({31'b0, wb_wr_en});
    raddr1 = 5'd5;
    #1;
    push("r5_arr", 32'hDEADBEEF);
    pop(rdata1);

    mem_waddr = 5'd0;
    mem_wdata = 32'hFFFFFFFF;
    mem_wr_en = 1'b1;
    push("r0_wb_en", 32'h1);
    push("r0_byp", 32'h0);
    step();
    mem_wr_en = 1'b0;
    raddr1 = 5'd0;
    #1;
    pop({31'b0, wb_wr_en});
    pop(rdata1);
    push("r0_after", 32'h0);
    step();
    pop(rdata1);

    mem_waddr = 5'd7;
    mem_wdata = 32'hA5A5A5A5;
    mem_wr_en = 1'b1;
    step();
    mem_waddr = 5'd8;
    mem_wdata = 32'h1;
    stall = 1'b1;
    raddr1 = 5'd7;
    raddr2 = 5'd8;
    for (int i = 0; i < 3; i++) begin
      push("stall_addr", 32'd7);
      push("stall_data", 32'hA5A5A5A5);
      push("stall_r7", 32'hA5A5A5A5);
`ifdef WB_FWD_MEM_EN
      push("stall_r8", 32'h1);
`else
      push("stall_r8", 32'h0);
`endif
      step();
      pop({27'b0, wb_waddr});
      pop(wb_wdata);
      pop(rdata1);
      pop(rdata2);
    end

    flush = 1'b1;
    push("flush_en", 32'h0);
    push("flush_r7", 32'hA5A5A5A5);
    push("flush_r8", 32'h0);
    step();
    stall = 1'b0;
    flush = 1'b0;
    mem_wr_en = 1'b0;
    #1;
    pop({31'b0, wb_wr_en});
    pop(rdata1);
    pop(rdata2);

    re2 = 1'b0;
    raddr2 = 5'd7;
    #1;
    push("re2_off", 32'h0);
    pop(rdata2);
    re2 = 1'b1;
    #1;
    push("re2_on", 32'hA5A5A5A5);
    pop(rdata2);

    mem_waddr = 5'd9;
    mem_wdata = 32'h11;
    mem_wr_en = 1'b1;
    step();
    mem_wdata = 32'h22;
    raddr1 = 5'd9;
    #1;
`ifdef WB_FWD_MEM_EN
    push("fwd_r9", 32'h22);
`else
    push("fwd_r9", 32'h11);
`endif
    pop(rdata1);
    push("r9_wb22", 32'h22);
    step();
    pop(rdata1);

    rst = 1'b0;
    push("mid_rst_en", 32'h0);
    push("mid_rst_rd", 32'h0);
    step();
    pop({31'b0, wb_wr_en});
    pop(rdata1);
    rst = 1'b1;
    mem_wr_en = 1'b0;
    raddr2 = 5'd7;
    #1;
    push("post_rst_r9", 32'h0);
    push("post_rst_r7", 32'h0);
    pop(rdata1);
    pop(rdata2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
